banked_unified_buffer: RTL and testbench

BANKED_UNIFIED_BUFFER -- requirements
Module: banked_unified_buffer

---
 rtl/banked_unified_buffer.sv | 170 +++++++++++++++++
 tb/tb_banked_unified_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/banked_unified_buffer.sv
// banked_unified_buffer: word-addressed buffer shared by a narrow host port and a
// wide burst engine that moves NUM_LANES lanes through BURST_LEN consecutive words.
// Host accesses are only accepted while no burst is running or being requested.
module banked_unified_buffer #(
   parameter int BUFFER_SIZE  = 1024,
   parameter int WORD_WIDTH   = 16,
   parameter int LANE_WIDTH   = 4,
   parameter int NUM_LANES    = 64,
   parameter int HOST_WIDTH   = 8,
   parameter int ADDRESS_SIZE = $clog2(BUFFER_SIZE),
   localparam int LPW         = WORD_WIDTH / LANE_WIDTH,
   localparam int BURST_LEN   = NUM_LANES / LPW,
   localparam int SECTIONS    = WORD_WIDTH / HOST_WIDTH,
   localparam int SEC_W       = (SECTIONS > 1) ? $clog2(SECTIONS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 host_valid,
   output logic                                 host_ready,
   input  logic                                 host_we,
   input  logic [ADDRESS_SIZE-1:0]              host_addr,
   input  logic [SEC_W-1:0]                     host_section,
   input  logic [HOST_WIDTH-1:0]                host_wdata,
   output logic [HOST_WIDTH-1:0]                host_rdata,
   output logic                                 host_rvalid,
   input  logic                                 burst_start,
   input  logic                                 burst_we,
   input  logic [ADDRESS_SIZE-1:0]              burst_addr,
   input  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] burst_in,
   output logic [NUM_LANES-1:0][LANE_WIDTH-1:0] burst_out,
   output logic                                 busy,
   output logic                                 done
);

   localparam int KW      = $clog2(BURST_LEN) + 1;
   localparam int AW1     = ADDRESS_SIZE + 1;
   localparam int LANES_W = NUM_LANES * LANE_WIDTH;
   localparam int OFF_W   = $clog2(LANES_W);
   localparam int SOFF_W  = $clog2(WORD_WIDTH);
   localparam logic [KW-1:0]  K_LAST = KW'(BURST_LEN - 1);
   localparam logic [AW1-1:0] BUF_SZ = AW1'(BUFFER_SIZE);

   if ((WORD_WIDTH % LANE_WIDTH) != 0 || (NUM_LANES % LPW) != 0 ||
       (WORD_WIDTH % HOST_WIDTH) != 0 || BURST_LEN > BUFFER_SIZE) begin : g_bad_params
      $error("banked_unified_buffer: inconsistent lane/word/host/burst parameters");
   end

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [KW-1:0]           k_q, k_d;
   logic                    done_d;
   logic                    start_acc;
   logic                    xfer;
   logic                    host_acc;
   logic                    sec_ok;
   logic                    we_q;
   logic [ADDRESS_SIZE-1:0] base_q;
   logic [ADDRESS_SIZE-1:0] xfer_addr;
   logic [AW1-1:0]          addr_sum;
   logic [OFF_W-1:0]        word_off;
   logic [SOFF_W-1:0]       sec_off;
   logic [LANES_W-1:0]      lanes_q;
   logic [LANES_W-1:0]      out_q;
   logic [WORD_WIDTH-1:0]   mem [BUFFER_SIZE];

   assign xfer       = (state_q == XFER);
   assign busy       = xfer;
   assign host_ready = !busy && !burst_start;
   assign host_acc   = host_valid && host_ready;
   assign sec_ok     = 32'(host_section) < 32'(SECTIONS);
   assign burst_out  = out_q;

   // Address and lane offset of the word moved this cycle; the base+k sum wraps at BUFFER_SIZE.
   always_comb begin
      addr_sum = AW1'(base_q) + AW1'(k_q);
      if (addr_sum >= BUF_SZ) begin
         addr_sum = addr_sum - BUF_SZ;
      end
      xfer_addr = addr_sum[ADDRESS_SIZE-1:0];
      word_off  = OFF_W'(k_q) * OFF_W'(WORD_WIDTH);
      sec_off   = sec_ok ? SOFF_W'(host_section) * SOFF_W'(HOST_WIDTH) : '0;
   end

   // Burst FSM next-state: IDLE accepts a start, XFER walks k up to the last word.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      done_d    = 1'b0;
      start_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (burst_start) begin
               start_acc = 1'b1;
               k_d       = '0;
               state_d   = XFER;
            end
         end
         XFER: begin
            if (k_q == K_LAST) begin
               state_d = IDLE;
               k_d     = '0;
               done_d  = 1'b1;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst control state; reset aborts an active burst without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         done    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         done    <= done_d;
         if (start_acc) begin
            we_q <= burst_we;
         end
      end
   end

   // Shadow copy of the burst request so the caller may change inputs during the burst.
   always_ff @(posedge clk) begin
      if (start_acc) begin
         base_q <= burst_addr;
         if (burst_we) begin
            lanes_q <= burst_in;
         end
      end
   end

   // Memory writes: burst words while transferring, otherwise one host section.
   always_ff @(posedge clk) begin
      if (xfer && we_q) begin
         mem[xfer_addr] <= lanes_q[word_off +: WORD_WIDTH];
      end else if (host_acc && host_we && sec_ok) begin
         mem[host_addr][sec_off +: HOST_WIDTH] <= host_wdata;
      end
   end

   // Registered host read data with a one-cycle valid strobe; data holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         host_rvalid <= host_acc && !host_we;
         if (host_acc && !host_we) begin
            host_rdata <= sec_ok ? mem[host_addr][sec_off +: HOST_WIDTH] : '0;
         end
      end
   end

   // Read-burst lanes fill one word per cycle and hold until the next read burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else if (xfer && !we_q) begin
         out_q[word_off +: WORD_WIDTH] <= mem[xfer_addr];
      end
   end

endmodule

// File: tb/tb_banked_unified_buffer.sv
// tb_banked_unified_buffer: directed checks of host access, bursts, wrap-around,
// contention, back-to-back bursts and mid-burst reset for banked_unified_buffer.
module tb_banked_unified_buffer;

   typedef logic [63:0][3:0] lanes_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         host_valid, host_ready, host_we, host_rvalid;
   logic [9:0]   host_addr;
   logic [0:0]   host_section;
   logic [7:0]   host_wdata, host_rdata;
   logic         burst_start, burst_we, busy, done;
   logic [9:0]   burst_addr;
   lanes_t       burst_in, burst_out;

   int checks = 0;
   int errors = 0;

   lanes_t     pat, fives;
   logic [7:0] d;
   logic       v, seen;
   int         nb, nb2;

   always #5 clk = ~clk;

   banked_unified_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_section (host_section),
      .host_wdata   (host_wdata),
      .host_rdata   (host_rdata),
      .host_rvalid  (host_rvalid),
      .burst_start  (burst_start),
      .burst_we     (burst_we),
      .burst_addr   (burst_addr),
      .burst_in     (burst_in),
      .burst_out    (burst_out),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [9:0] a, input logic s, input logic [7:0] wd);
      host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_section = s; host_wdata = wd;
      step();
      host_valid = 1'b0; host_we = 1'b0;
   endtask

   task automatic host_read(input logic [9:0] a, input logic s, output logic [7:0] rd, output logic rv);
      host_valid = 1'b1; host_we = 1'b0; host_addr = a; host_section = s;
      step();
      host_valid = 1'b0;
      rd = host_rdata;
      rv = host_rvalid;
   endtask

   task automatic start_burst(input logic we, input logic [9:0] a, input lanes_t lanes);
      burst_start = 1'b1; burst_we = we; burst_addr = a; burst_in = lanes;
      step();
      burst_start = 1'b0;
   endtask

   task automatic wait_done(output int n, output logic s);
      n = 0;
      s = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin
            s = 1'b1;
            break;
         end
         if (busy) n++;
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         pat[i]   = 4'(i % 16);
         fives[i] = 4'h5;
      end
      host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_section = '0; host_wdata = '0;
      burst_start = 1'b0; burst_we = 1'b0; burst_addr = '0; burst_in = '0;

      // reset state
      #2 rst = 1'b1;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rvalid", host_rvalid, 0);
      chk("rst_rdata", host_rdata, 0);
      chk("rst_burst_out", burst_out, 0);
      chk("rst_host_ready", host_ready, 1);
      step(); step();
      rst = 1'b0;
      step();

      // host section writes and reads
      host_write(10'd5, 1'b0, 8'hAB);
      host_write(10'd5, 1'b1, 8'hCD);
      host_read(10'd5, 1'b1, d, v);
      chk("host_rd_s1", d, 8'hCD);
      chk("host_rvalid_s1", v, 1);
      step();
      chk("host_rvalid_clear", host_rvalid, 0);
      chk("host_rdata_hold", host_rdata, 8'hCD);
      host_read(10'd5, 1'b0, d, v);
      chk("host_rd_s0", d, 8'hAB);
      chk("host_rvalid_s0", v, 1);

      // write burst at 0x010
      start_burst(1'b1, 10'h010, pat);
      wait_done(nb, seen);
      chk("wr_busy_len", nb, 16);
      chk("wr_done_seen", seen, 1);
      step();
      chk("wr_done_pulse", done, 0);
      chk("wr_busy_after", busy, 0);
      host_read(10'h010, 1'b0, d, v);
      chk("wr_w0_s0", d, 8'h10);
      host_read(10'h010, 1'b1, d, v);
      chk("wr_w0_s1", d, 8'h32);
      host_read(10'h011, 1'b0, d, v);
      chk("wr_w1_s0", d, 8'h54);

      // wrap-around write then read at 1020
      start_burst(1'b1, 10'd1020, pat);
      wait_done(nb, seen);
      chk("wrap_wr_seen", seen, 1);
      start_burst(1'b0, 10'd1020, '0);
      wait_done(nb, seen);
      chk("wrap_rd_len", nb, 16);
      chk("wrap_rd_seen", seen, 1);
      chk("wrap_burst_out", burst_out, pat);
      host_read(10'd0, 1'b0, d, v);
      chk("wrap_addr0_s0", d, 8'h10);
      host_read(10'd11, 1'b1, d, v);
      chk("wrap_addr11_s1", d, 8'hFE);

      // contention: host and second start during busy
      host_write(10'h300, 1'b0, 8'h77);
      start_burst(1'b1, 10'h040, pat);
      host_valid = 1'b1; host_we = 1'b1; host_addr = 10'h300; host_section = 1'b0; host_wdata = 8'h99;
      burst_start = 1'b1; burst_we = 1'b1; burst_addr = 10'h080; burst_in = fives;
      #1;
      chk("cont_host_ready", host_ready, 0);
      nb = 0;
      for (int c = 0; c < 4; c++) begin
         if (busy) nb++;
         step();
      end
      host_valid = 1'b0; host_we = 1'b0; burst_start = 1'b0;
      wait_done(nb2, seen);
      chk("cont_busy_len", nb + nb2, 16);
      chk("cont_done_seen", seen, 1);
      step();
      chk("cont_no_restart", busy, 0);
      host_read(10'h300, 1'b0, d, v);
      chk("cont_mem_kept", d, 8'h77);
      host_read(10'h040, 1'b1, d, v);
      chk("cont_burst_wr", d, 8'h32);

      // back-to-back: read burst requested in the done cycle
      start_burst(1'b1, 10'h200, pat);
      wait_done(nb, seen);
      chk("b2b_first_len", nb, 16);
      burst_start = 1'b1; burst_we = 1'b0; burst_addr = 10'h200; burst_in = '0;
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd5; host_section = 1'b0;
      #1;
      chk("b2b_done_cycle", done, 1);
      chk("b2b_host_ready", host_ready, 0);
      step();
      burst_start = 1'b0; host_valid = 1'b0;
      chk("b2b_busy_no_gap", busy, 1);
      chk("b2b_no_rvalid", host_rvalid, 0);
      wait_done(nb, seen);
      chk("b2b_second_len", nb, 16);
      chk("b2b_burst_out", burst_out, pat);

      // reset after eight words of a write burst
      start_burst(1'b1, 10'h100, fives);
      wait_done(nb, seen);
      chk("pre_fill_seen", seen, 1);
      start_burst(1'b1, 10'h100, pat);
      for (int c = 0; c < 8; c++) step();
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_burst_out", burst_out, 0);
      step();
      rst = 1'b0;
      step();
      chk("mid_rst_no_resume", busy, 0);
      chk("mid_rst_no_done", done, 0);
      host_read(10'h100, 1'b0, d, v);
      chk("mid_w0_written", d, 8'h10);
      host_read(10'h107, 1'b1, d, v);
      chk("mid_w7_written", d, 8'hFE);
      host_read(10'h108, 1'b0, d, v);
      chk("mid_w8_kept", d, 8'h55);
      host_read(10'h10F, 1'b1, d, v);
      chk("mid_w15_kept", d, 8'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
